jtag_tap_ctrl: RTL

- IEEE 1149.1-style TAP controller and scan engine that acts as the DUT-side endpoint consuming the TMS/TDI stream produced by the jtag interface package's driver BFM.
- Returns TDO to that BFM's monitor.
- Implements the 16-state TAP FSM, an instruction register and three data registers: BYPASS, IDCODE and an optional USER register.
- Exposes state and register contents so the jtag environment's scoreboard can check them directly.

---
 rtl/jtag_tap_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/jtag_tap_ctrl.sv
// TAP controller and scan engine: 16-state FSM, instruction register, BYPASS/IDCODE/USER data registers.
// The USER data register is present only when JTAG_USER_DR_EN is defined; otherwise USER_OPC decodes as BYPASS.
module jtag_tap_ctrl #(
    parameter int                   IR_WIDTH   = 4,
    parameter int                   DR_WIDTH   = 32,
    parameter logic [31:0]          IDCODE_VAL = 32'h1234_5679,
    parameter logic [IR_WIDTH-1:0]  IDCODE_OPC = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0]  USER_OPC   = IR_WIDTH'(2)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_tms,
    input  logic                i_tdi,
    output logic                o_tdo,
    output logic                o_tdo_en,
    output logic [3:0]          o_tap_state,
    output logic [IR_WIDTH-1:0] o_ir_out,
    input  logic [DR_WIDTH-1:0] i_user_dr_in,
    output logic [DR_WIDTH-1:0] o_user_dr_out,
    output logic                o_update_dr_pulse
);

    // state  | meaning
    // TLR  F | test-logic-reset
    // RTI  C | run-test/idle
    // *_DR   | SEL 7, CAP 6, SH 2, EX1 1, PA 3, EX2 0, UPD 5
    // *_IR   | SEL 4, CAP E, SH A, EX1 9, PA B, EX2 8, UPD D
    localparam logic [3:0] S_TLR    = 4'hF;
    localparam logic [3:0] S_RTI    = 4'hC;
    localparam logic [3:0] S_SEL_DR = 4'h7;
    localparam logic [3:0] S_CAP_DR = 4'h6;
    localparam logic [3:0] S_SH_DR  = 4'h2;
    localparam logic [3:0] S_EX1_DR = 4'h1;
    localparam logic [3:0] S_PA_DR  = 4'h3;
    localparam logic [3:0] S_EX2_DR = 4'h0;
    localparam logic [3:0] S_UPD_DR = 4'h5;
    localparam logic [3:0] S_SEL_IR = 4'h4;
    localparam logic [3:0] S_CAP_IR = 4'hE;
    localparam logic [3:0] S_SH_IR  = 4'hA;
    localparam logic [3:0] S_EX1_IR = 4'h9;
    localparam logic [3:0] S_PA_IR  = 4'hB;
    localparam logic [3:0] S_EX2_IR = 4'h8;
    localparam logic [3:0] S_UPD_IR = 4'hD;

    logic [3:0]          r_state;
    logic [3:0]          w_next;
    logic [IR_WIDTH-1:0] r_ir_shift;
    logic [IR_WIDTH-1:0] r_ir_out;
    logic [31:0]         r_id_shift;
    logic                r_bypass;
    logic                w_sel_id;
    logic                w_sel_user;
    logic                w_user_bit;
    logic                w_tdo;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_TLR:    w_next = i_tms ? S_TLR    : S_RTI;
            S_RTI:    w_next = i_tms ? S_SEL_DR : S_RTI;
            S_SEL_DR: w_next = i_tms ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: w_next = i_tms ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  w_next = i_tms ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: w_next = i_tms ? S_UPD_DR : S_PA_DR;
            S_PA_DR:  w_next = i_tms ? S_EX2_DR : S_PA_DR;
            S_EX2_DR: w_next = i_tms ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: w_next = i_tms ? S_SEL_DR : S_RTI;
            S_SEL_IR: w_next = i_tms ? S_TLR    : S_CAP_IR;
            S_CAP_IR: w_next = i_tms ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  w_next = i_tms ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: w_next = i_tms ? S_UPD_IR : S_PA_IR;
            S_PA_IR:  w_next = i_tms ? S_EX2_IR : S_PA_IR;
            S_EX2_IR: w_next = i_tms ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: w_next = i_tms ? S_SEL_DR : S_RTI;
            default:  w_next = S_TLR;
        endcase
    end

    assign w_sel_id = (r_ir_out == IDCODE_OPC);

    // IR is forced to IDCODE on the edge that enters TLR, so it already reads IDCODE in the first TLR cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_TLR;
            r_ir_shift <= '0;
            r_ir_out   <= IDCODE_OPC;
            r_id_shift <= '0;
            r_bypass   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TLR)
                r_ir_out <= IDCODE_OPC;
            else if (r_state == S_UPD_IR)
                r_ir_out <= r_ir_shift;
            case (r_state)
                S_CAP_IR: r_ir_shift <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
                S_SH_IR:  r_ir_shift <= {i_tdi, r_ir_shift[IR_WIDTH-1:1]};
                S_CAP_DR: begin
                    if (w_sel_id)
                        r_id_shift <= IDCODE_VAL;
                    else if (!w_sel_user)
                        r_bypass <= 1'b0;
                end
                S_SH_DR: begin
                    if (w_sel_id)
                        r_id_shift <= {i_tdi, r_id_shift[31:1]};
                    else if (!w_sel_user)
                        r_bypass <= i_tdi;
                end
                default: ;
            endcase
        end
    end

`ifdef JTAG_USER_DR_EN
    logic [DR_WIDTH-1:0] r_user_shift;
    logic [DR_WIDTH-1:0] r_user_out;

    assign w_sel_user = (r_ir_out == USER_OPC) && !w_sel_id;
    assign w_user_bit = r_user_shift[0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_user_shift <= '0;
            r_user_out   <= '0;
        end else if (w_sel_user) begin
            case (r_state)
                S_CAP_DR: r_user_shift <= i_user_dr_in;
                S_SH_DR:  r_user_shift <= {i_tdi, r_user_shift[DR_WIDTH-1:1]};
                S_UPD_DR: r_user_out   <= r_user_shift;
                default:  ;
            endcase
        end
    end

    assign o_user_dr_out     = r_user_out;
    assign o_update_dr_pulse = (r_state == S_UPD_DR) && w_sel_user;
`else
    logic w_unused_user_in;

    assign w_unused_user_in  = ^i_user_dr_in;
    assign w_sel_user        = 1'b0;
    assign w_user_bit        = 1'b0;
    assign o_user_dr_out     = '0;
    assign o_update_dr_pulse = 1'b0;
`endif

    always_comb begin
        w_tdo = 1'b0;
        if (r_state == S_SH_IR)
            w_tdo = r_ir_shift[0];
        else if (r_state == S_SH_DR) begin
            if (w_sel_id)
                w_tdo = r_id_shift[0];
            else if (w_sel_user)
                w_tdo = w_user_bit;
            else
                w_tdo = r_bypass;
        end
    end

    assign o_tdo       = w_tdo;
    assign o_tdo_en    = (r_state == S_SH_DR) || (r_state == S_SH_IR);
    assign o_tap_state = r_state;
    assign o_ir_out    = r_ir_out;

endmodule
